// File: rtl/cra_sbr_stack.sv
// Microcode CALL/RETURN subroutine stack for the CRAM address path; the top-of-stack feeds the CRA dispatch mux.
// Optional per-entry odd parity with a sticky parityErr output is enabled by defining CRA_SBR_PARITY_EN.
module cra_sbr_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          advance,
  input  logic          call,
  input  logic          force1777,
  input  logic          ret,
  input  logic [AW-1:0] pushAdr,
  input  logic          diaClear,
  input  logic [4:0]    diagIdx,
  output logic [AW-1:0] sbrRet,
  output logic [4:0]    stackAdr,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow,
`ifdef CRA_SBR_PARITY_EN
  output logic          parityErr,
`endif
  output logic [AW-1:0] diagData
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 6;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Requests only take effect on a committed microinstruction (advance=1);
  // a page-fail trap during a RETURN is a push and never a pop.
  logic do_push;
  logic do_pop;
  assign do_push = advance & (call | force1777);
  assign do_pop  = advance & ret & ~force1777;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ret_q, ret_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] mem_q [DEPTH];

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          chk_en;
  logic [IW-1:0] chk_idx;
  logic [CW-1:0] cnt_m1;
  logic [CW-1:0] cnt_m2;
  logic          is_empty;
  logic          is_full;

  assign cnt_m1   = cnt_q - CW'(1);
  assign cnt_m2   = cnt_q - CW'(2);
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_FULL);

  always_comb begin
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    chk_en  = 1'b0;
    chk_idx = '0;
    if (diaClear) begin
      cnt_d = '0;
      ret_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          // Entry index is modulo DEPTH, so a push while full wraps onto entry 0.
          wr_en  = 1'b1;
          wr_idx = cnt_q[IW-1:0];
          ret_d  = pushAdr;
          if (is_full) ovf_d = 1'b1;
          else         cnt_d = cnt_q + CW'(1);
        end
        2'b01: begin
          if (is_empty) begin
            ret_d = '0;
            unf_d = 1'b1;
          end else begin
            cnt_d = cnt_m1;
            if (cnt_q >= CW'(2)) begin
              ret_d   = mem_q[cnt_m2[IW-1:0]];
              chk_en  = 1'b1;
              chk_idx = cnt_m2[IW-1:0];
            end else begin
              ret_d = '0;
            end
          end
        end
        2'b11: begin
          wr_en = 1'b1;
          ret_d = pushAdr;
          if (is_empty) begin
            wr_idx = '0;
            cnt_d  = CW'(1);
          end else begin
            wr_idx  = cnt_m1[IW-1:0];
            chk_en  = 1'b1;
            chk_idx = cnt_m1[IW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
      ret_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ret_q <= ret_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (wr_en) mem_q[wr_idx] <= pushAdr;
    end
  end

`ifdef CRA_SBR_PARITY_EN
  function automatic logic odd_par(input logic [AW-1:0] d);
    return ~^d;
  endfunction

  logic mem_par_q [DEPTH];
  logic par_err_q;
  logic par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if (diaClear)
      par_err_d = 1'b0;
    else if (chk_en && (mem_par_q[chk_idx] != odd_par(mem_q[chk_idx])))
      par_err_d = 1'b1;
  end

  // Cleared entries hold data 0, whose odd-parity bit is 1.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      par_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_par_q[i] <= 1'b1;
    end else begin
      par_err_q <= par_err_d;
      if (wr_en) mem_par_q[wr_idx] <= odd_par(pushAdr);
    end
  end

  assign parityErr = par_err_q;
`else
  logic unused_par;
  assign unused_par = chk_en ^ (^chk_idx);
`endif

  // stackAdr is 5 bits wide; at DEPTH=32 a full stack reads 0 there, while full still reports it.
  assign sbrRet    = ret_q;
  assign stackAdr  = cnt_q[4:0];
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign diagData  = mem_q[diagIdx[IW-1:0]];

  logic unused_ok;
  assign unused_ok = ^{diagIdx, cnt_m1, cnt_m2};

endmodule
